// File: rtl/boreal_interconnect_if.sv
// Boreal interconnect bus bundle: both master request/response ports and
// all nine slave ports. The crossbar takes the "slave" view (it serves the
// masters and drives the slave selects); the environment takes "master".
interface boreal_interconnect_if;
  // Public master
  logic        pub_req, pub_wr;
  logic [31:0] pub_addr, pub_wdata, pub_rdata;
  logic [3:0]  pub_strb;
  logic        pub_ack, pub_err;
  // Gate master
  logic        gate_req, gate_wr;
  logic [31:0] gate_addr, gate_wdata, gate_rdata;
  logic [3:0]  gate_strb;
  logic        gate_ack, gate_err;
  // ROM (read-only port, writes complete on rom_ack without a wr strobe)
  logic        rom_sel, rom_ack;
  logic [31:0] rom_addr, rom_rdata;
  // SRAM (only slave with byte strobes)
  logic        sram_sel, sram_wr, sram_ack;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [3:0]  sram_strb;
  // Register-style slaves
  logic        dma_sel, dma_wr, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        vec_sel, vec_wr, vec_ack;
  logic [31:0] vec_addr, vec_wdata, vec_rdata;
  logic        aimbox_sel, aimbox_wr, aimbox_ack;
  logic [31:0] aimbox_addr, aimbox_wdata, aimbox_rdata;
  logic        dvm_sel, dvm_wr, dvm_ack;
  logic [31:0] dvm_addr, dvm_wdata, dvm_rdata;
  logic        gatereg_sel, gatereg_wr, gatereg_ack;
  logic [31:0] gatereg_addr, gatereg_wdata, gatereg_rdata;
  logic        ledger_sel, ledger_wr, ledger_ack;
  logic [31:0] ledger_addr, ledger_wdata, ledger_rdata;
  logic        priv_sel, priv_wr, priv_ack;
  logic [31:0] priv_addr, priv_wdata, priv_rdata;

  modport slave (
    input  pub_req, pub_wr, pub_addr, pub_wdata, pub_strb,
    output pub_rdata, pub_ack, pub_err,
    input  gate_req, gate_wr, gate_addr, gate_wdata, gate_strb,
    output gate_rdata, gate_ack, gate_err,
    output rom_sel, rom_addr, input rom_rdata, rom_ack,
    output sram_sel, sram_wr, sram_addr, sram_wdata, sram_strb, input sram_rdata, sram_ack,
    output dma_sel, dma_wr, dma_addr, dma_wdata, input dma_rdata, dma_ack,
    output vec_sel, vec_wr, vec_addr, vec_wdata, input vec_rdata, vec_ack,
    output aimbox_sel, aimbox_wr, aimbox_addr, aimbox_wdata, input aimbox_rdata, aimbox_ack,
    output dvm_sel, dvm_wr, dvm_addr, dvm_wdata, input dvm_rdata, dvm_ack,
    output gatereg_sel, gatereg_wr, gatereg_addr, gatereg_wdata, input gatereg_rdata, gatereg_ack,
    output ledger_sel, ledger_wr, ledger_addr, ledger_wdata, input ledger_rdata, ledger_ack,
    output priv_sel, priv_wr, priv_addr, priv_wdata, input priv_rdata, priv_ack
  );

  modport master (
    output pub_req, pub_wr, pub_addr, pub_wdata, pub_strb,
    input  pub_rdata, pub_ack, pub_err,
    output gate_req, gate_wr, gate_addr, gate_wdata, gate_strb,
    input  gate_rdata, gate_ack, gate_err,
    input  rom_sel, rom_addr, output rom_rdata, rom_ack,
    input  sram_sel, sram_wr, sram_addr, sram_wdata, sram_strb, output sram_rdata, sram_ack,
    input  dma_sel, dma_wr, dma_addr, dma_wdata, output dma_rdata, dma_ack,
    input  vec_sel, vec_wr, vec_addr, vec_wdata, output vec_rdata, vec_ack,
    input  aimbox_sel, aimbox_wr, aimbox_addr, aimbox_wdata, output aimbox_rdata, aimbox_ack,
    input  dvm_sel, dvm_wr, dvm_addr, dvm_wdata, output dvm_rdata, dvm_ack,
    input  gatereg_sel, gatereg_wr, gatereg_addr, gatereg_wdata, output gatereg_rdata, gatereg_ack,
    input  ledger_sel, ledger_wr, ledger_addr, ledger_wdata, output ledger_rdata, ledger_ack,
    input  priv_sel, priv_wr, priv_addr, priv_wdata, output priv_rdata, priv_ack
  );
endinterface

// File: rtl/boreal_interconnect.sv
// Boreal two-master / nine-slave single-transfer crossbar.
// Gate has fixed priority; PRIV window is Gate-only. Decode and response
// paths are combinational; an owner register holds the grant across slave
// wait states. Optional slave watchdog: define BOREAL_IC_TIMEOUT_EN.
module boreal_interconnect #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  boreal_interconnect_if.slave bus
);
  localparam int NS = 9;  // 0 ROM,1 SRAM,2 DMA,3 VEC,4 AIMBOX,5 DVM,6 GATEREG,7 LEDGER,8 PRIV
  localparam int PRIV = 8;

  typedef enum logic [1:0] {IDLE, OWN_PUB, OWN_GATE} own_e;
  own_e own_q, own_d;

  logic                 gnt_pub, gnt_gate, gnt;
  logic                 m_wr;
  logic [31:0]          m_addr, m_wdata;
  logic [3:0]           m_strb;
  logic [NS-1:0]        hit, sel, s_ack_v;
  logic [NS-1:0][31:0]  s_rdata_v;
  logic                 illegal, to_fire, x_ack, x_err;
  logic [31:0]          x_rdata;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  // One-hot region decode; all-zero means unmapped.
  function automatic logic [NS-1:0] decode(input logic [31:0] a);
    decode = '0;
    if (a[31:12] == 20'h0_0000) decode[0] = 1'b1;
    else if (a[31:12] >= 20'h0_0001 && a[31:12] <= 20'h0_0004) decode[1] = 1'b1;
    else if (a[31:16] == 16'h1000) begin
      case (a[15:12])
        4'h0: decode[2] = 1'b1;
        4'h1: decode[3] = 1'b1;
        4'h2: decode[4] = 1'b1;
        4'h3: decode[5] = 1'b1;
        4'h4: decode[6] = 1'b1;
        4'h5: decode[7] = 1'b1;
        default: ;
      endcase
    end
    else if (a[31:16] == 16'h2000) decode[PRIV] = 1'b1;
  endfunction

  // Grant: owner keeps the bus while it requests; otherwise Gate beats Public.
  always_comb begin
    gnt_pub  = 1'b0;
    gnt_gate = 1'b0;
    if (!rst) begin
      case (own_q)
        IDLE: begin
          gnt_gate = bus.gate_req;
          gnt_pub  = !bus.gate_req && bus.pub_req;
        end
        OWN_PUB:  gnt_pub  = bus.pub_req;
        OWN_GATE: gnt_gate = bus.gate_req;
        default: ;
      endcase
    end
  end
  assign gnt = gnt_pub | gnt_gate;

  // Request mux and decode; everything reads zero without a grant.
  always_comb begin
    m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_strb = '0;
    if (gnt_gate) begin
      m_wr = bus.gate_wr; m_addr = bus.gate_addr; m_wdata = bus.gate_wdata; m_strb = bus.gate_strb;
    end else if (gnt_pub) begin
      m_wr = bus.pub_wr;  m_addr = bus.pub_addr;  m_wdata = bus.pub_wdata;  m_strb = bus.pub_strb;
    end
    hit     = decode(m_addr);
    illegal = gnt && ((hit == '0) || (hit[PRIV] && gnt_pub));
    sel     = (gnt && !illegal && !to_fire) ? hit : '0;
  end

  assign s_ack_v   = {bus.priv_ack, bus.ledger_ack, bus.gatereg_ack, bus.dvm_ack,
                      bus.aimbox_ack, bus.vec_ack, bus.dma_ack, bus.sram_ack, bus.rom_ack};
  assign s_rdata_v = {bus.priv_rdata, bus.ledger_rdata, bus.gatereg_rdata, bus.dvm_rdata,
                      bus.aimbox_rdata, bus.vec_rdata, bus.dma_rdata, bus.sram_rdata, bus.rom_rdata};

  // Response mux from the selected slave, overridden on error.
  always_comb begin
    x_ack   = 1'b0;
    x_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel[i]) begin
        x_ack   = x_ack | s_ack_v[i];
        x_rdata = x_rdata | s_rdata_v[i];
      end
    end
    x_err = illegal | (gnt & to_fire);
    if (x_err) x_rdata = ERR_RDATA;
  end

  assign bus.pub_ack    = gnt_pub & x_ack;
  assign bus.pub_err    = gnt_pub & x_err;
  assign bus.pub_rdata  = gnt_pub ? x_rdata : '0;
  assign bus.gate_ack   = gnt_gate & x_ack;
  assign bus.gate_err   = gnt_gate & x_err;
  assign bus.gate_rdata = gnt_gate ? x_rdata : '0;

  assign bus.rom_sel = sel[0]; assign bus.rom_addr = m_addr;
  assign bus.sram_sel = sel[1]; assign bus.sram_wr = m_wr; assign bus.sram_addr = m_addr;
  assign bus.sram_wdata = m_wdata; assign bus.sram_strb = m_strb;
  assign bus.dma_sel = sel[2]; assign bus.dma_wr = m_wr;
  assign bus.dma_addr = m_addr; assign bus.dma_wdata = m_wdata;
  assign bus.vec_sel = sel[3]; assign bus.vec_wr = m_wr;
  assign bus.vec_addr = m_addr; assign bus.vec_wdata = m_wdata;
  assign bus.aimbox_sel = sel[4]; assign bus.aimbox_wr = m_wr;
  assign bus.aimbox_addr = m_addr; assign bus.aimbox_wdata = m_wdata;
  assign bus.dvm_sel = sel[5]; assign bus.dvm_wr = m_wr;
  assign bus.dvm_addr = m_addr; assign bus.dvm_wdata = m_wdata;
  assign bus.gatereg_sel = sel[6]; assign bus.gatereg_wr = m_wr;
  assign bus.gatereg_addr = m_addr; assign bus.gatereg_wdata = m_wdata;
  assign bus.ledger_sel = sel[7]; assign bus.ledger_wr = m_wr;
  assign bus.ledger_addr = m_addr; assign bus.ledger_wdata = m_wdata;
  assign bus.priv_sel = sel[8]; assign bus.priv_wr = m_wr;
  assign bus.priv_addr = m_addr; assign bus.priv_wdata = m_wdata;

  // Owner next state: hold only while the granted transfer is still pending.
  always_comb begin
    own_d = IDLE;
    if (gnt && !x_ack && !x_err) own_d = gnt_gate ? OWN_GATE : OWN_PUB;
  end

  // Owner register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) own_q <= IDLE;
    else     own_q <= own_d;
  end

`ifdef BOREAL_IC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_q, to_cnt_d;

  assign to_fire = (own_q != IDLE) && (to_cnt_q == CW'(TIMEOUT_CYCLES));

  // Count owned wait cycles; restart whenever the bus goes back to IDLE.
  always_comb begin
    to_cnt_d = '0;
    if (own_d != IDLE) to_cnt_d = to_cnt_q + 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign to_fire = 1'b0;
`endif
endmodule

// File: tb/tb_boreal_interconnect.sv
// Scoreboard bench for boreal_interconnect: each driven cycle pushes the
// expected response, checked at the following falling edge.
module tb_boreal_interconnect;
  localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  boreal_interconnect_if bus();
  boreal_interconnect #(.TIMEOUT_CYCLES(16), .ERR_RDATA(ERR_RD)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  // Slave models: per-slave ack enable, read data tagged with slave index.
  logic [8:0] ack_en;
  function automatic logic [31:0] srd(input int i, input logic [31:0] a);
    return {4'hA, 4'(i), a[23:0]};
  endfunction
  assign bus.rom_ack     = ack_en[0]; assign bus.rom_rdata     = srd(0, bus.rom_addr);
  assign bus.sram_ack    = ack_en[1]; assign bus.sram_rdata    = srd(1, bus.sram_addr);
  assign bus.dma_ack     = ack_en[2]; assign bus.dma_rdata     = srd(2, bus.dma_addr);
  assign bus.vec_ack     = ack_en[3]; assign bus.vec_rdata     = srd(3, bus.vec_addr);
  assign bus.aimbox_ack  = ack_en[4]; assign bus.aimbox_rdata  = srd(4, bus.aimbox_addr);
  assign bus.dvm_ack     = ack_en[5]; assign bus.dvm_rdata     = srd(5, bus.dvm_addr);
  assign bus.gatereg_ack = ack_en[6]; assign bus.gatereg_rdata = srd(6, bus.gatereg_addr);
  assign bus.ledger_ack  = ack_en[7]; assign bus.ledger_rdata  = srd(7, bus.ledger_addr);
  assign bus.priv_ack    = ack_en[8]; assign bus.priv_rdata    = srd(8, bus.priv_addr);

  wire [8:0] sel_v = {bus.priv_sel, bus.ledger_sel, bus.gatereg_sel, bus.dvm_sel,
                      bus.aimbox_sel, bus.vec_sel, bus.dma_sel, bus.sram_sel, bus.rom_sel};

  typedef struct {
    string       tag;
    logic [8:0]  sel;
    logic        pa, pe, ga, ge, wr;
    logic [31:0] prd, grd, addr, wd;
    logic [3:0]  strb;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Address map model; -1 = unmapped.
  function automatic int region(input logic [31:0] a);
    if (a <= 32'h0000_0FFF) return 0;
    if (a >= 32'h0000_1000 && a <= 32'h0000_4FFF) return 1;
    if (a >= 32'h1000_0000 && a <= 32'h1000_5FFF) return 2 + int'((a - 32'h1000_0000) >> 12);
    if (a >= 32'h2000_0000 && a <= 32'h2000_FFFF) return 8;
    return -1;
  endfunction

  task automatic drive(input logic pr, input logic pwr, input logic [31:0] pa,
                       input logic gr, input logic gwr, input logic [31:0] ga);
    bus.pub_req  = pr; bus.pub_wr  = pwr; bus.pub_addr  = pa;
    bus.pub_wdata = pa ^ 32'h5A5A_0000; bus.pub_strb = 4'h3;
    bus.gate_req = gr; bus.gate_wr = gwr; bus.gate_addr = ga;
    bus.gate_wdata = ga ^ 32'hC3C3_0000; bus.gate_strb = 4'hC;
  endtask

  // owner: 0 idle, 1 public holds, 2 gate holds, 3 reset (no grant)
  task automatic predict(input string tag, input int owner);
    exp_t e;
    logic gg, gp, any, ill, ok, ack;
    logic [31:0] a, rd;
    int r;
    gg = 0; gp = 0;
    if (owner == 0) begin gg = bus.gate_req; gp = !bus.gate_req && bus.pub_req; end
    else if (owner == 1) gp = bus.pub_req;
    else if (owner == 2) gg = bus.gate_req;
    any = gg | gp;
    e.tag  = tag;
    a      = gg ? bus.gate_addr  : gp ? bus.pub_addr  : 32'h0;
    e.addr = a;
    e.wr   = gg ? bus.gate_wr    : gp ? bus.pub_wr    : 1'b0;
    e.wd   = gg ? bus.gate_wdata : gp ? bus.pub_wdata : 32'h0;
    e.strb = gg ? bus.gate_strb  : gp ? bus.pub_strb  : 4'h0;
    r   = any ? region(a) : -1;
    ill = any && (r < 0 || (r == 8 && gp));
    ok  = any && !ill;
    e.sel = ok ? (9'd1 << r) : 9'd0;
    ack = ok ? ack_en[r] : 1'b0;
    rd  = ill ? ERR_RD : ok ? srd(r, a) : 32'h0;
    e.pa = gp & ack; e.pe = gp & ill; e.prd = gp ? rd : 32'h0;
    e.ga = gg & ack; e.ge = gg & ill; e.grd = gg ? rd : 32'h0;
    sb.push_back(e);
  endtask

  // Check the pending expectation mid-cycle, then advance to next drive point.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk({e.tag, ".sel"},   32'(sel_v), 32'(e.sel));
      chk({e.tag, ".pub"},   32'({bus.pub_ack, bus.pub_err}), 32'({e.pa, e.pe}));
      chk({e.tag, ".prd"},   bus.pub_rdata, e.prd);
      chk({e.tag, ".gate"},  32'({bus.gate_ack, bus.gate_err}), 32'({e.ga, e.ge}));
      chk({e.tag, ".grd"},   bus.gate_rdata, e.grd);
      chk({e.tag, ".addr"},  bus.dvm_addr, e.addr);
      chk({e.tag, ".wr"},    32'(bus.sram_wr), 32'(e.wr));
      chk({e.tag, ".wdata"}, bus.sram_wdata, e.wd);
      chk({e.tag, ".strb"},  32'(bus.sram_strb), 32'(e.strb));
    end
    @(posedge clk); #1;
  endtask

  // One zero-wait transfer from IDLE followed by an idle cycle.
  task automatic xfer(input string tag, input logic pr, input logic pwr, input logic [31:0] pa,
                      input logic gr, input logic gwr, input logic [31:0] ga);
    drive(pr, pwr, pa, gr, gwr, ga);
    predict(tag, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    predict({tag, ".idle"}, 0); step();
  endtask

  initial begin
    ack_en = '1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    // Requests during reset see no grant
    drive(1, 0, 32'h0, 1, 0, 32'h2000_0000);
    predict("rst", 3); step();
    rst = 1'b0;

    xfer("rom_rd",    1, 0, 32'h0000_0000, 0, 0, 0);
    xfer("rom_top",   1, 0, 32'h0000_0FFF, 0, 0, 0);
    xfer("rom_wr",    1, 1, 32'h0000_0010, 0, 0, 0);
    xfer("sram_lo",   1, 0, 32'h0000_1000, 0, 0, 0);
    xfer("sram_hi",   1, 1, 32'h0000_4FFF, 0, 0, 0);
    xfer("sram_past", 1, 0, 32'h0000_5000, 0, 0, 0);
    xfer("dma",       1, 0, 32'h1000_0000, 0, 0, 0);
    xfer("vec_g",     0, 0, 0,             1, 0, 32'h1000_1ABC);
    xfer("aimbox_wr", 1, 1, 32'h1000_2000, 0, 0, 0);
    xfer("dvm_g",     0, 0, 0,             1, 1, 32'h1000_3004);
    xfer("gatereg",   1, 0, 32'h1000_4000, 0, 0, 0);
    xfer("ledger",    1, 0, 32'h1000_5FFF, 0, 0, 0);
    xfer("gap",       1, 0, 32'h1000_6000, 0, 0, 0);
    xfer("priv_pub",  1, 0, 32'h2000_0000, 0, 0, 0);
    xfer("priv_g",    0, 0, 0,             1, 0, 32'h2000_0000);
    xfer("priv_gtop", 0, 0, 0,             1, 1, 32'h2000_FFFF);
    xfer("priv_past", 0, 0, 0,             1, 0, 32'h2001_0000);
    xfer("unmapped",  1, 0, 32'h3000_0000, 0, 0, 0);
    xfer("both",      1, 0, 32'h0000_1000, 1, 0, 32'h1000_0000);
    xfer("both_gerr", 1, 0, 32'h0000_0000, 1, 0, 32'h3000_0000);

    // Lock: public waits on SRAM while Gate requests
    ack_en[1] = 1'b0;
    drive(1, 0, 32'h0000_1000, 0, 0, 0);
    predict("lock0", 0); step();
    drive(1, 0, 32'h0000_1000, 1, 0, 32'h1000_0000);
    predict("lock1", 1); step();
    predict("lock2", 1); step();
    ack_en[1] = 1'b1;
    predict("lock3", 1); step();
    drive(0, 0, 0, 1, 0, 32'h1000_0000);
    predict("lock4", 0); step();
    drive(0, 0, 0, 0, 0, 0);
    predict("lock.idle", 0); step();

    // Abort: owner drops req mid-wait; Gate served the cycle after
    ack_en[2] = 1'b0;
    drive(1, 0, 32'h1000_0000, 0, 0, 0);
    predict("abt0", 0); step();
    drive(0, 0, 0, 1, 0, 32'h0000_0100);
    predict("abt1", 1); step();
    predict("abt2", 0); step();
    ack_en = '1;
    drive(0, 0, 0, 0, 0, 0);
    predict("abt.idle", 0); step();

    // Reset mid-transfer clears the owner
    ack_en[1] = 1'b0;
    drive(1, 0, 32'h0000_2000, 0, 0, 0);
    predict("rmid0", 0); step();
    rst = 1'b1;
    predict("rmid1", 3); step();
    rst = 1'b0;
    drive(1, 0, 32'h0000_2000, 1, 0, 32'h1000_3000);
    predict("rmid2", 0); step();
    ack_en = '1;
    drive(0, 0, 0, 0, 0, 0);
    predict("rmid.idle", 0); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/boreal_interconnect.md
Name: boreal_interconnect

Overview:
- Two-master, nine-slave single-transfer bus crossbar for the Boreal SoC.
- Public master (CPU/DMA side) and Gate master (security gate) share one path to ROM, SRAM, DMA, VEC, AIMBOX, DVM, GATEREG, LEDGER and Privileged I/O.
- Gate has fixed priority; the Privileged I/O window is reachable only from Gate.
- Decode and response routing are combinational; a small owner register holds the grant across multi-cycle slave waits.

Parameters:
- TIMEOUT_CYCLES, 16: slave-response watchdog limit; used only with BOREAL_IC_TIMEOUT_EN.
- ERR_RDATA, 32'h0000_0000: read data returned to a master on an error response.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pub_req, pub_wr  in  1 each  public request; write when 1, read when 0
- pub_addr, pub_wdata  in  32 each  public byte address and write data
- pub_strb  in  4  public byte strobes
- pub_rdata  out  32  public read data
- pub_ack, pub_err  out  1 each  public completion / error
- gate_req, gate_wr, gate_addr, gate_wdata, gate_strb  in  same widths as public  Gate request
- gate_rdata, gate_ack, gate_err  out  32/1/1  Gate response
- rom_sel  out 1; rom_addr  out 32; rom_rdata  in 32; rom_ack  in 1  (read-only, no wr or wdata)
- sram_sel, sram_wr  out 1; sram_addr, sram_wdata  out 32; sram_strb  out 4; sram_rdata  in 32; sram_ack  in 1
- For each X in dma, vec, aimbox, dvm, gatereg, ledger, priv: X_sel, X_wr  out 1; X_addr, X_wdata  out 32; X_rdata  in 32; X_ack  in 1

Behaviour:
- Address map (inclusive ranges); any other address is unmapped:
  - ROM 0x0000_0000–0x0000_0FFF
  - SRAM 0x0000_1000–0x0000_4FFF
  - DMA 0x1000_0000–0x1000_0FFF
  - VEC 0x1000_1000–0x1000_1FFF
  - AIMBOX 0x1000_2000–0x1000_2FFF
  - DVM 0x1000_3000–0x1000_3FFF
  - GATEREG 0x1000_4000–0x1000_4FFF
  - LEDGER 0x1000_5000–0x1000_5FFF
  - PRIV 0x2000_0000–0x2000_FFFF
- Owner register states: IDLE, OWN_PUB, OWN_GATE. Reset value IDLE.
- Grant in IDLE: gate_req wins; else pub_req; else no grant.
- Grant in OWN_x: x keeps the grant regardless of the other master's request.
- Only the granted master's addr, wr, wdata and strb drive all slave addr/wr/wdata/strb outputs.
- Exactly one X_sel is high: the one whose region matches, while a grant exists and the access is legal. All X_sel are 0 otherwise.
- Illegal access = unmapped address, or public master targeting PRIV.
  - Illegal access: no X_sel asserted; granted master gets err=1, ack=0, rdata=ERR_RDATA in the same cycle.
- Legal access: granted master's ack = selected slave's ack, rdata = that slave's rdata, err=0. Zero-wait slaves complete in the request cycle.
- Non-granted master: ack=0, err=0, rdata=0; it stalls until granted.
- Owner update at each clk edge:
  - Granted master's req=1 with no ack/err this cycle: owner = that master.
  - ack or err, or owner's req drops (abort): owner = IDLE.
- With no grant, all outputs are 0. Same for all combinational outputs while rst is high, and owner forced to IDLE.
- Reset mid-transfer: owner → IDLE immediately; the transfer is abandoned with no ack.
- Writes to ROM are routed like reads (rom_sel=1, no rom_wr); ROM ack completes them.

Optional Feature:
- BOREAL_IC_TIMEOUT_EN defined: a counter runs while owner≠IDLE and no ack.
  - On reaching TIMEOUT_CYCLES, the owner gets err=1 for one cycle, sel drops, owner → IDLE.
  - Counter clears on completion or reset.
- Undefined: no counter; a stalled slave holds the bus indefinitely.

Test Plan:
- pub read 0x0000_0000, ROM acks combinationally → rom_sel=1, pub_ack=1, pub_err=0, pub_rdata=rom_rdata, same cycle.
- pub read 0x0000_1000 → sram_sel=1, pub_ack=1. pub read 0x1000_0000 → dma_sel=1, pub_ack=1, all other sels 0.
- pub read 0x2000_0000 → pub_err=1, priv_sel=0, pub_ack=0. gate read 0x2000_0000 → priv_sel=1, gate_ack=1, gate_err=0.
- pub read 0x3000_0000 → pub_err=1, no sel asserted, pub_rdata=ERR_RDATA.
- pub 0x0000_1000 and gate 0x1000_0000 requested together → dma_sel=1, sram_sel=0, gate_ack=1, pub_ack=0.
- Lock: public to SRAM with sram_ack held 0 for 3 cycles while gate_req rises → sram_sel stays 1, gate_ack=0 until sram_ack; gate is then served next cycle.
